// File: rtl/sprite_rom_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sprite_rom_arbiter_if
// Brief    : Request/grant bus between the figure pipelines, the sprite ROM
//            and the sprite ROM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface sprite_rom_arbiter_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 3
);
    logic              req1;
    logic              req2;
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    logic              gnt1;
    logic              gnt2;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic              valid1;
    logic              valid2;

    // Arbiter side
    modport slave (
        input  req1, req2, addr1, addr2, rom_data,
        output gnt1, gnt2, rom_addr, data1, data2, valid1, valid2
    );

    // Requester / ROM side
    modport master (
        output req1, req2, addr1, addr2, rom_data,
        input  gnt1, gnt2, rom_addr, data1, data2, valid1, valid2
    );
endinterface
`default_nettype wire

// File: rtl/sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sprite_rom_arbiter
// Brief    : Round-robin sharing of the sprite ROM read port between the two
//            figure pipelines, with the pixel code steered back to its owner.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_rom_arbiter #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 3
) (
    input  wire logic              Clk,
    input  wire logic              Reset,
    sprite_rom_arbiter_if.slave    bus
);

    localparam logic c_LAST_1 = 1'b0;
    localparam logic c_LAST_2 = 1'b1;

    logic              r_last;
    logic              w_gnt1;
    logic              w_gnt2;
    logic              r_s1_valid;
    logic              r_s1_id;
    logic [DATA_W-1:0] r_data1;
    logic [DATA_W-1:0] r_data2;
    logic              r_valid1;
    logic              r_valid2;

    // Contention goes to whichever requester was not served last.
    always_comb begin
        w_gnt1 = 1'b0;
        w_gnt2 = 1'b0;
        if (!Reset) begin
            if (bus.req1 && (!bus.req2 || r_last == c_LAST_2)) begin
                w_gnt1 = 1'b1;
            end else if (bus.req2) begin
                w_gnt2 = 1'b1;
            end
        end
    end

    assign bus.gnt1     = w_gnt1;
    assign bus.gnt2     = w_gnt2;
    assign bus.rom_addr = w_gnt1 ? bus.addr1 :
                          w_gnt2 ? bus.addr2 : '0;
    assign bus.data1    = r_data1;
    assign bus.data2    = r_data2;
    assign bus.valid1   = r_valid1;
    assign bus.valid2   = r_valid2;

    // Stage 1 tags the grant; stage 2 lines up with the ROM's registered output.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_last     <= c_LAST_2;
            r_s1_valid <= 1'b0;
            r_s1_id    <= 1'b0;
            r_data1    <= '0;
            r_data2    <= '0;
            r_valid1   <= 1'b0;
            r_valid2   <= 1'b0;
        end else begin
            if (w_gnt1 || w_gnt2) begin
                r_last <= w_gnt2 ? c_LAST_2 : c_LAST_1;
            end
            r_s1_valid <= w_gnt1 || w_gnt2;
            r_s1_id    <= w_gnt2;
            r_valid1   <= r_s1_valid && !r_s1_id;
            r_valid2   <= r_s1_valid &&  r_s1_id;
            if (r_s1_valid && !r_s1_id) begin
                r_data1 <= bus.rom_data;
            end
            if (r_s1_valid && r_s1_id) begin
                r_data2 <= bus.rom_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_rom_arbiter
// Brief    : Self-checking bench for sprite_rom_arbiter with a response
//            scoreboard keyed on grant cycle and requester.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_rom_arbiter;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 3;

    typedef struct {
        int                id;
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;

    logic              Clk   = 1'b0;
    logic              Reset = 1'b1;
    int                checks = 0;
    int                errors = 0;
    int                cyc    = 0;
    exp_t              sb[$];
    logic [DATA_W-1:0] exp_data1 = '0;
    logic [DATA_W-1:0] exp_data2 = '0;

    always #10 Clk = ~Clk;

    sprite_rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    sprite_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
        if (a == 19'h00123) return 3'd5;
        return a[2:0] ^ a[5:3] ^ a[8:6] ^ 3'd1;
    endfunction

    // Registered-output ROM model
    always @(posedge Clk) bus.rom_data <= rom_fn(bus.rom_addr);

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req1 = 1'b0;
        bus.req2 = 1'b0;
    endtask

    // Scoreboard: grants are pushed, valid strobes pop and compare.
    task automatic monitor_loop();
        forever begin
            @(negedge Clk);
            cyc++;
            checks++;
            if (bus.gnt1 && bus.gnt2) begin
                errors++;
                $display("FAIL gnt_exclusive: got gnt1=%0b gnt2=%0b, required not both", bus.gnt1, bus.gnt2);
            end
            checks++;
            if (bus.valid1) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_valid1: got unexpected valid1 data1=%0d, required no valid", bus.data1);
                end else begin
                    exp_t e = sb.pop_front();
                    if (e.id !== 1 || e.cyc !== cyc - 2 || bus.data1 !== e.data) begin
                        errors++;
                        $display("FAIL sb_valid1: got id=1 cyc=%0d data=%0d, required id=%0d cyc=%0d data=%0d",
                                 cyc, bus.data1, e.id, e.cyc + 2, e.data);
                    end
                    exp_data1 = e.data;
                end
            end else if (bus.data1 !== exp_data1) begin
                errors++;
                $display("FAIL hold_data1: got %0d, required %0d", bus.data1, exp_data1);
            end
            checks++;
            if (bus.valid2) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_valid2: got unexpected valid2 data2=%0d, required no valid", bus.data2);
                end else begin
                    exp_t e = sb.pop_front();
                    if (e.id !== 2 || e.cyc !== cyc - 2 || bus.data2 !== e.data) begin
                        errors++;
                        $display("FAIL sb_valid2: got id=2 cyc=%0d data=%0d, required id=%0d cyc=%0d data=%0d",
                                 cyc, bus.data2, e.id, e.cyc + 2, e.data);
                    end
                    exp_data2 = e.data;
                end
            end else if (bus.data2 !== exp_data2) begin
                errors++;
                $display("FAIL hold_data2: got %0d, required %0d", bus.data2, exp_data2);
            end
            if (Reset) begin
                sb.delete();
                exp_data1 = '0;
                exp_data2 = '0;
            end else begin
                if (bus.req1 && bus.gnt1) sb.push_back('{1, rom_fn(bus.addr1), cyc});
                if (bus.req2 && bus.gnt2) sb.push_back('{2, rom_fn(bus.addr2), cyc});
            end
        end
    endtask

    task automatic drain_and_check(input string name);
        repeat (3) step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d pending responses, required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        bus.req1 = 1'b1; bus.addr1 = 19'h10;
        bus.req2 = 1'b1; bus.addr2 = 19'h20;
        repeat (2) begin
            @(negedge Clk);
            checks++;
            if (bus.gnt1 !== 1'b0 || bus.gnt2 !== 1'b0 || bus.rom_addr !== '0) begin
                errors++;
                $display("FAIL reset_gnt: got gnt1=%0b gnt2=%0b rom_addr=%0h, required 0 0 0",
                         bus.gnt1, bus.gnt2, bus.rom_addr);
            end
            checks++;
            if (bus.valid1 !== 1'b0 || bus.valid2 !== 1'b0 || bus.data1 !== '0 || bus.data2 !== '0) begin
                errors++;
                $display("FAIL reset_out: got v1=%0b v2=%0b d1=%0d d2=%0d, required all 0",
                         bus.valid1, bus.valid2, bus.data1, bus.data2);
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_single();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        bus.req1 = 1'b1; bus.addr1 = 19'h00123;
        @(negedge Clk);
        checks++;
        if (bus.gnt1 !== 1'b1 || bus.gnt2 !== 1'b0 || bus.rom_addr !== 19'h00123) begin
            errors++;
            $display("FAIL single_gnt: got gnt1=%0b gnt2=%0b rom_addr=%0h, required 1 0 123",
                     bus.gnt1, bus.gnt2, bus.rom_addr);
        end
        step();
        bus.req1 = 1'b0;
        step();
        @(negedge Clk);
        checks++;
        if (bus.valid1 !== 1'b1 || bus.data1 !== 3'd5 || bus.valid2 !== 1'b0) begin
            errors++;
            $display("FAIL single_valid: got v1=%0b d1=%0d v2=%0b, required 1 5 0",
                     bus.valid1, bus.data1, bus.valid2);
        end
        step();
        repeat (2) begin
            @(negedge Clk);
            checks++;
            if (bus.valid2 !== 1'b0 || bus.data2 !== '0) begin
                errors++;
                $display("FAIL single_fig2: got v2=%0b d2=%0d, required 0 0", bus.valid2, bus.data2);
            end
            step();
        end
    endtask

    task automatic test_contention();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        bus.req1 = 1'b1; bus.addr1 = 19'h10;
        bus.req2 = 1'b1; bus.addr2 = 19'h20;
        for (int i = 0; i < 6; i++) begin
            logic e1;
            e1 = (i % 2 == 0);
            @(negedge Clk);
            checks++;
            if (bus.gnt1 !== e1 || bus.gnt2 !== !e1 || bus.rom_addr !== (e1 ? 19'h10 : 19'h20)) begin
                errors++;
                $display("FAIL contention_gnt%0d: got gnt1=%0b gnt2=%0b rom_addr=%0h, required gnt1=%0b",
                         i, bus.gnt1, bus.gnt2, bus.rom_addr, e1);
            end
            step();
        end
        idle_inputs();
        drain_and_check("contention");
    endtask

    task automatic test_priority();
        bus.addr1 = 19'h31; bus.addr2 = 19'h32;
        bus.req2 = 1'b1;
        @(negedge Clk);
        checks++;
        if (bus.gnt2 !== 1'b1) begin
            errors++;
            $display("FAIL prio_alone2: got gnt2=%0b, required 1", bus.gnt2);
        end
        step();
        bus.req1 = 1'b1;
        @(negedge Clk);
        checks++;
        if (bus.gnt1 !== 1'b1 || bus.gnt2 !== 1'b0) begin
            errors++;
            $display("FAIL prio_after2: got gnt1=%0b gnt2=%0b, required 1 0", bus.gnt1, bus.gnt2);
        end
        step();
        bus.req2 = 1'b0;
        @(negedge Clk);
        checks++;
        if (bus.gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL prio_alone1: got gnt1=%0b, required 1", bus.gnt1);
        end
        step();
        bus.req2 = 1'b1;
        @(negedge Clk);
        checks++;
        if (bus.gnt1 !== 1'b0 || bus.gnt2 !== 1'b1) begin
            errors++;
            $display("FAIL prio_after1: got gnt1=%0b gnt2=%0b, required 0 1", bus.gnt1, bus.gnt2);
        end
        step();
        idle_inputs();
        drain_and_check("priority");
    endtask

    task automatic test_withdraw();
        bus.req1 = 1'b1; bus.addr1 = 19'h40;
        bus.req2 = 1'b1; bus.addr2 = 19'h50;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            checks++;
            if (bus.gnt1 !== 1'b1 || bus.gnt2 !== 1'b0) begin
                errors++;
                $display("FAIL withdraw_gnt%0d: got gnt1=%0b gnt2=%0b, required 1 0", i, bus.gnt1, bus.gnt2);
            end
            step();
            bus.req2  = 1'b0;
            bus.addr1 = 19'h41;
        end
        bus.req1 = 1'b1; bus.addr1 = 19'h42;
        bus.req2 = 1'b1;
        @(negedge Clk);
        checks++;
        if (bus.gnt2 !== 1'b1 || bus.rom_addr !== 19'h50) begin
            errors++;
            $display("FAIL withdraw_last: got gnt2=%0b rom_addr=%0h, required 1 50", bus.gnt2, bus.rom_addr);
        end
        step();
        idle_inputs();
        drain_and_check("withdraw");
    endtask

    task automatic test_reset_midstream();
        bus.req1 = 1'b1; bus.addr1 = 19'h55;
        @(negedge Clk);
        checks++;
        if (bus.gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL midrst_gnt0: got gnt1=%0b, required 1", bus.gnt1);
        end
        step();
        Reset = 1'b1;
        bus.req1 = 1'b0;
        bus.req2 = 1'b1; bus.addr2 = 19'h66;
        @(negedge Clk);
        checks++;
        if (bus.gnt1 !== 1'b0 || bus.gnt2 !== 1'b0 || bus.rom_addr !== '0) begin
            errors++;
            $display("FAIL midrst_gnt1: got gnt1=%0b gnt2=%0b rom_addr=%0h, required 0 0 0",
                     bus.gnt1, bus.gnt2, bus.rom_addr);
        end
        step();
        Reset = 1'b0;
        bus.req1 = 1'b1; bus.addr1 = 19'h57;
        @(negedge Clk);
        checks++;
        if (bus.valid1 !== 1'b0 || bus.data1 !== '0 || bus.gnt1 !== 1'b1 || bus.gnt2 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after: got v1=%0b d1=%0d gnt1=%0b gnt2=%0b, required 0 0 1 0",
                     bus.valid1, bus.data1, bus.gnt1, bus.gnt2);
        end
        step();
        bus.req1 = 1'b0;
        @(negedge Clk);
        checks++;
        if (bus.gnt2 !== 1'b1 || bus.rom_addr !== 19'h66) begin
            errors++;
            $display("FAIL midrst_next: got gnt2=%0b rom_addr=%0h, required 1 66", bus.gnt2, bus.rom_addr);
        end
        step();
        idle_inputs();
        drain_and_check("midrst");
    endtask

    task automatic test_idle();
        idle_inputs();
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            checks++;
            if (bus.gnt1 !== 1'b0 || bus.gnt2 !== 1'b0 || bus.rom_addr !== '0 ||
                bus.valid1 !== 1'b0 || bus.valid2 !== 1'b0 ||
                bus.data1 !== exp_data1 || bus.data2 !== exp_data2) begin
                errors++;
                $display("FAIL idle%0d: got g1=%0b g2=%0b ra=%0h v1=%0b v2=%0b d1=%0d d2=%0d, required 0 0 0 0 0 %0d %0d",
                         i, bus.gnt1, bus.gnt2, bus.rom_addr, bus.valid1, bus.valid2,
                         bus.data1, bus.data2, exp_data1, exp_data2);
            end
            step();
        end
    endtask

    initial begin
        bus.req1  = 1'b0;
        bus.req2  = 1'b0;
        bus.addr1 = '0;
        bus.addr2 = '0;
        fork
            monitor_loop();
        join_none
        @(posedge Clk);
        #1;
        test_reset();
        test_single();
        test_contention();
        test_priority();
        test_withdraw();
        test_reset_midstream();
        test_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
